// File: rtl/up_regmap_bank.sv
// Parameterised up-bus register bank with RW / W1C / W1S / RO bit classes.
// Optional interrupt mask register and irq output when REGMAP_IRQ_EN is defined.

module up_regmap_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RST        = '0,
  parameter logic [DATA_WIDTH-1:0] RW         = '1,
  parameter logic [DATA_WIDTH-1:0] W1C        = '0,
  parameter logic [DATA_WIDTH-1:0] W1S        = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] hw_ro,
  input  logic [DATA_WIDTH-1:0] hw_set,
  output logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] pulse,
  output logic [DATA_WIDTH-1:0] rval
);
  // W1C beats W1S beats RW; whatever is left is read-only
  localparam logic [DATA_WIDTH-1:0] C_W1C   = W1C;
  localparam logic [DATA_WIDTH-1:0] C_W1S   = W1S & ~W1C;
  localparam logic [DATA_WIDTH-1:0] C_RW    = RW & ~W1C & ~W1S;
  localparam logic [DATA_WIDTH-1:0] C_STORE = C_RW | C_W1C;
  localparam logic [DATA_WIDTH-1:0] C_RO    = ~(C_STORE | C_W1S);

  logic [DATA_WIDTH-1:0] rw_nxt, w1c_nxt;

  assign rw_nxt  = we ? wdata : q;
  // hw_set is applied after the clear so a simultaneous set wins
  assign w1c_nxt = (q & ~(we ? wdata : '0)) | hw_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= RST & C_STORE;
      pulse <= '0;
    end else begin
      q     <= (rw_nxt & C_RW) | (w1c_nxt & C_W1C);
      pulse <= we ? (wdata & C_W1S) : '0;
    end
  end

  assign rval = q | (hw_ro & C_RO);
endmodule

module up_regmap_bank #(
  parameter int                                NUM_REGS    = 8,
  parameter int                                DATA_WIDTH  = 32,
  parameter int                                ADDR_WIDTH  = 14,
  parameter logic [ADDR_WIDTH-1:0]             BASE_ADDR   = 'h0000,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]    RESET_VALUE = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]    RW_MASK     = '1,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]    W1C_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]    W1S_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           up_wreq,
  input  logic [ADDR_WIDTH-1:0]          up_waddr,
  input  logic [DATA_WIDTH-1:0]          up_wdata,
  output logic                           up_wack,
  input  logic                           up_rreq,
  input  logic [ADDR_WIDTH-1:0]          up_raddr,
  output logic [DATA_WIDTH-1:0]          up_rdata,
  output logic                           up_rack,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_pulse
`ifdef REGMAP_IRQ_EN
  ,
  output logic                           irq
`endif
);
  logic [NUM_REGS-1:0]                 wsel, rsel;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] q_arr, pulse_arr, rval;
  logic [DATA_WIDTH-1:0]               rd_mux;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign wsel[i] = up_wreq && (up_waddr == BASE_ADDR + ADDR_WIDTH'(i));
    assign rsel[i] = up_rreq && (up_raddr == BASE_ADDR + ADDR_WIDTH'(i));

    up_regmap_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .RST        (RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH]),
      .RW         (RW_MASK[i*DATA_WIDTH +: DATA_WIDTH]),
      .W1C        (W1C_MASK[i*DATA_WIDTH +: DATA_WIDTH]),
      .W1S        (W1S_MASK[i*DATA_WIDTH +: DATA_WIDTH])
    ) u_reg (
      .clk    (clk),
      .reset  (reset),
      .we     (wsel[i]),
      .wdata  (up_wdata),
      .hw_ro  (hw_ro[i*DATA_WIDTH +: DATA_WIDTH]),
      .hw_set (hw_set[i*DATA_WIDTH +: DATA_WIDTH]),
      .q      (q_arr[i]),
      .pulse  (pulse_arr[i]),
      .rval   (rval[i])
    );
  end

  assign reg_q     = q_arr;
  assign reg_pulse = pulse_arr;

`ifdef REGMAP_IRQ_EN
  logic [NUM_REGS-1:0] irq_mask, pend;
  logic                msel_w, msel_r;

  assign msel_w = up_wreq && (up_waddr == BASE_ADDR + ADDR_WIDTH'(NUM_REGS));
  assign msel_r = up_rreq && (up_raddr == BASE_ADDR + ADDR_WIDTH'(NUM_REGS));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_pend
    assign pend[i] = |(q_arr[i] & W1C_MASK[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (msel_w) irq_mask <= up_wdata[NUM_REGS-1:0];
      irq <= |(irq_mask & pend);
    end
  end
`endif

  // Only selected lanes contribute, so idle and out-of-range reads give zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rsel[i]) rd_mux |= rval[i];
`ifdef REGMAP_IRQ_EN
    if (msel_r) rd_mux |= DATA_WIDTH'(irq_mask);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      up_wack  <= 1'b0;
      up_rack  <= 1'b0;
      up_rdata <= '0;
    end else begin
      up_wack  <= up_wreq;
      up_rack  <= up_rreq;
      up_rdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_up_regmap_bank.sv
// Scoreboard bench for up_regmap_bank: directed scenarios then random traffic
// against a per-register behavioural model.

module tb_up_regmap_bank;
  localparam int NR = 8;
  localparam int DW = 32;
  localparam int AW = 14;
  localparam int NB = NR*DW;
  localparam logic [AW-1:0] BASE = 14'h100;

  localparam logic [NB-1:0] RST = {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004,
                                   32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
  localparam logic [NB-1:0] RWM = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0000FFFF,
                                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam logic [NB-1:0] W1C = {32'h00000000, 32'h0000FF00, 32'h00000000, 32'h00000000,
                                   32'h00000000, 32'h00000001, 32'h00000000, 32'h00000000};
  localparam logic [NB-1:0] W1S = {32'h0000000F, 32'h00000000, 32'h00000000, 32'h00000000,
                                   32'h00000010, 32'h00000001, 32'h00000000, 32'h00000000};

  logic clk = 1'b0;
  logic reset, up_wreq, up_rreq, up_wack, up_rack;
  logic [AW-1:0] up_waddr, up_raddr;
  logic [DW-1:0] up_wdata, up_rdata;
  logic [NB-1:0] hw_ro, hw_set, reg_q, reg_pulse;
`ifdef REGMAP_IRQ_EN
  logic irq;
`endif

  up_regmap_bank #(
    .NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
    .RESET_VALUE(RST), .RW_MASK(RWM), .W1C_MASK(W1C), .W1S_MASK(W1S)
  ) dut (
    .clk(clk), .reset(reset),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .hw_ro(hw_ro), .hw_set(hw_set), .reg_q(reg_q), .reg_pulse(reg_pulse)
`ifdef REGMAP_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wack, rack, irq;
    logic [NB-1:0] pulse, q;
  } exp_t;

  exp_t          exp_cyc[$];
  logic [DW-1:0] exp_rd[$];
  int            checks = 0, errors = 0;

  // model state: stored contents per register, bit classes by precedence
  logic [DW-1:0] m_q [NR];
  logic [DW-1:0] c_rw [NR], c_w1c [NR], c_w1s [NR], c_ro [NR];
  logic [NR-1:0] m_mask = '0;

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    int k = int'(a) - int'(BASE);
    if (k >= 0 && k < NR) return m_q[k] | (hw_ro[k*DW +: DW] & c_ro[k]);
`ifdef REGMAP_IRQ_EN
    if (k == NR) return DW'(m_mask);
`endif
    return '0;
  endfunction

  task automatic step(input logic rst, input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic rd, input logic [AW-1:0] ra, input logic [NB-1:0] set);
    exp_t e;
    int   wk;
    reset = rst; up_wreq = wr; up_waddr = wa; up_wdata = wd;
    up_rreq = rd; up_raddr = ra; hw_set = set;
    e.wack = !rst && wr;
    e.rack = !rst && rd;
    e.irq = 1'b0;
    e.pulse = '0;
    if (e.rack) exp_rd.push_back(model_rd(ra));
`ifdef REGMAP_IRQ_EN
    for (int i = 0; i < NR; i++)
      if (m_mask[i] && (m_q[i] & c_w1c[i]) != 0) e.irq = !rst;
`endif
    wk = int'(wa) - int'(BASE);
    if (rst) begin
      for (int i = 0; i < NR; i++) m_q[i] = RST[i*DW +: DW] & (c_rw[i] | c_w1c[i]);
      m_mask = '0;
    end else begin
      if (wr && wk >= 0 && wk < NR) begin
        m_q[wk] = (m_q[wk] & ~c_rw[wk]) | (wd & c_rw[wk]);
        m_q[wk] = m_q[wk] & ~(wd & c_w1c[wk]);
        e.pulse[wk*DW +: DW] = wd & c_w1s[wk];
      end
`ifdef REGMAP_IRQ_EN
      if (wr && wk == NR) m_mask = wd[NR-1:0];
`endif
      for (int i = 0; i < NR; i++) m_q[i] = m_q[i] | (set[i*DW +: DW] & c_w1c[i]);
    end
    for (int i = 0; i < NR; i++) e.q[i*DW +: DW] = m_q[i];
    exp_cyc.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();                                        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0); endtask
  task automatic wr(input int k, input logic [DW-1:0] d);       step(1'b0, 1'b1, AW'(int'(BASE) + k), d, 1'b0, '0, '0); endtask
  task automatic rd(input int k);                               step(1'b0, 1'b0, '0, '0, 1'b1, AW'(int'(BASE) + k), '0); endtask
  task automatic hset(input int bitn);
    logic [NB-1:0] s = '0;
    s[bitn] = 1'b1;
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, s);
  endtask

  // monitor: per-cycle outputs plus read data popped only on up_rack
  always @(negedge clk) begin
    exp_t e;
    if (exp_cyc.size() > 0) begin
      e = exp_cyc.pop_front();
      chk("wack", NB'(up_wack), NB'(e.wack));
      chk("rack", NB'(up_rack), NB'(e.rack));
      chk("reg_pulse", reg_pulse, e.pulse);
      chk("reg_q", reg_q, e.q);
`ifdef REGMAP_IRQ_EN
      chk("irq", NB'(irq), NB'(e.irq));
`endif
      if (up_rack) begin
        if (exp_rd.size() == 0) chk("rack_unexpected", NB'(up_rack), NB'(1'b0));
        else chk("rdata", NB'(up_rdata), NB'(exp_rd.pop_front()));
      end else begin
        chk("rdata_idle", NB'(up_rdata), '0);
      end
    end
  end

  initial begin
    logic [NB-1:0] s;
    for (int i = 0; i < NR; i++) begin
      c_w1c[i] = W1C[i*DW +: DW];
      c_w1s[i] = W1S[i*DW +: DW] & ~c_w1c[i];
      c_rw[i]  = RWM[i*DW +: DW] & ~c_w1c[i] & ~c_w1s[i];
      c_ro[i]  = ~(c_w1c[i] | c_w1s[i] | c_rw[i]);
      m_q[i]   = '0;
    end
    for (int i = 0; i < NR; i++) hw_ro[i*DW +: DW] = 32'h5A000000 | 32'(i);

    // reset with requests and strobes present: nothing acked, nothing set
    step(1'b1, 1'b1, BASE, '1, 1'b1, BASE, '1);
    step(1'b1, 1'b1, BASE + 14'd2, '1, 1'b1, BASE + 14'd4, '1);
    idle();

    // reset values, one past the bank, and one below it
    for (int k = -1; k <= NR; k++) rd(k);

    wr(1, 32'hA5A5A5A5);
    rd(1);
    wr(40, 32'hFFFFFFFF);
    for (int k = 0; k < NR; k++) rd(k);

    // W1C on register 2 bit 0
    hset(64);
    rd(2);
    step(1'b0, 1'b1, BASE + 14'd2, 32'h1, 1'b0, '0, NB'(1) << 64);
    rd(2);
    wr(2, 32'h1);
    rd(2);

    // W1S pulse on register 3 bit 4
    wr(3, 32'h10);
    idle();
    rd(3);

    // same-cycle write/read returns the old value, then reset mid-stream
    wr(1, 32'h0);
    step(1'b0, 1'b1, BASE + 14'd1, 32'h1234, 1'b1, BASE + 14'd1, '0);
    rd(1);
    rd(1);
    step(1'b1, 1'b0, '0, '0, 1'b1, BASE + 14'd1, '0);
    rd(1);

`ifdef REGMAP_IRQ_EN
    wr(2, 32'h1);
    hset(64);
    idle(); idle();
    wr(NR, 32'h4);
    idle(); idle();
    rd(NR);
    wr(2, 32'h1);
    idle(); idle();
`endif

    // back-to-back random traffic
    for (int n = 0; n < 600; n++) begin
      logic          r, w, q;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd;
      for (int i = 0; i < NR; i++) begin
        s[i*DW +: DW] = $urandom & $urandom & $urandom;
        hw_ro[i*DW +: DW] = $urandom;
      end
      r  = ($urandom_range(0, 59) == 0);
      w  = $urandom_range(0, 1) == 1;
      q  = $urandom_range(0, 1) == 1;
      wa = ($urandom_range(0, 9) == 0) ? AW'(int'(BASE) + 40)
                                       : AW'(int'(BASE) - 2 + int'($urandom_range(0, NR + 3)));
      ra = AW'(int'(BASE) - 2 + int'($urandom_range(0, NR + 3)));
      wd = ($urandom_range(0, 3) == 0) ? '1 : DW'($urandom);
      step(r, w, wa, wd, q, ra, s);
    end

    idle(); idle(); idle();
    chk("rd_queue_drained", NB'(exp_rd.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/up_regmap_bank.md
UP_REGMAP_BANK -- requirements
Module: up_regmap_bank

Interface
REQ-001 Parameter NUM_REGS, default 8, number of registers (1..32).
REQ-002 Parameter DATA_WIDTH, default 32, register width in bits.
REQ-003 Parameter ADDR_WIDTH, default 14, up bus word-address width.
REQ-004 Parameter BASE_ADDR, default 'h0000, word address of register 0.
REQ-005 Parameter RESET_VALUE, NUM_REGS*DATA_WIDTH bits, default all 0, reset value per register.
REQ-006 Parameter RW_MASK, NUM_REGS*DATA_WIDTH bits, default all 1, marks read/write bits.
REQ-007 Parameter W1C_MASK, NUM_REGS*DATA_WIDTH bits, default all 0, marks write-1-to-clear status bits.
REQ-008 Parameter W1S_MASK, NUM_REGS*DATA_WIDTH bits, default all 0, marks write-1-to-set self-clearing pulse bits.
REQ-009 Port list:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-high reset.
- up_wreq  input  1  write request.
- up_waddr  input  ADDR_WIDTH  write word address.
- up_wdata  input  DATA_WIDTH  write data.
- up_wack  output  1  write acknowledge.
- up_rreq  input  1  read request.
- up_raddr  input  ADDR_WIDTH  read word address.
- up_rdata  output  DATA_WIDTH  read data.
- up_rack  output  1  read acknowledge.
- hw_ro  input  NUM_REGS*DATA_WIDTH  live values for read-only bits.
- hw_set  input  NUM_REGS*DATA_WIDTH  per-bit set strobes for W1C bits.
- reg_q  output  NUM_REGS*DATA_WIDTH  current RW and W1C register contents.
- reg_pulse  output  NUM_REGS*DATA_WIDTH  one-cycle W1S pulses.
- irq  output  1  interrupt (only with REGMAP_IRQ_EN).

Function
REQ-010 Bit class precedence SHALL be W1C_MASK, then W1S_MASK, then RW_MASK; all other bits are RO.
REQ-011 Register i SHALL decode at word address BASE_ADDR+i; other addresses SHALL be out of range.
REQ-012 up_wack SHALL assert exactly one cycle after each cycle with up_wreq=1, for in-range and out-of-range addresses.
REQ-013 An in-range write SHALL update RW bits to up_wdata on the clock edge sampling up_wreq.
REQ-014 A W1C bit SHALL clear where up_wdata=1; hw_set=1 SHALL set it; simultaneous set and clear SHALL leave it 1.
REQ-015 A W1S bit written with 1 SHALL drive reg_pulse high for exactly the cycle after the write, otherwise 0.
REQ-016 up_rack SHALL assert exactly one cycle after each cycle with up_rreq=1; up_rdata SHALL be registered with that latency.
REQ-017 up_rdata SHALL carry RW and W1C contents, hw_ro sampled at request, and 0 for W1S bits.
REQ-018 up_rdata SHALL be 0 whenever up_rack=0 and for out-of-range reads.
REQ-019 Same-cycle read and write to one address SHALL return the pre-write value.
REQ-020 Back-to-back requests every cycle SHALL be accepted without stall; no request SHALL be dropped.
REQ-021 Out-of-range writes SHALL change no state.

Reset
REQ-022 While reset=1: registers load RESET_VALUE (RO/W1S bits ignored); up_wack, up_rack, reg_pulse, irq = 0; up_rdata = 0.
REQ-023 Requests sampled while reset=1 SHALL not be acknowledged; acknowledges pending when reset asserts SHALL be dropped.
REQ-024 hw_set while reset=1 SHALL be ignored.

Configuration
REQ-025 Macro REGMAP_IRQ_EN defined: internal IRQ mask register at BASE_ADDR+NUM_REGS, RW, reset 0; bit i enables register i.
REQ-026 With REGMAP_IRQ_EN: irq SHALL be registered, high one cycle after any enabled register has a set W1C bit.
REQ-027 Without REGMAP_IRQ_EN: no irq port; address BASE_ADDR+NUM_REGS is out of range.

Verification
REQ-028 Reset, then read all registers -> up_rack one cycle later each, up_rdata equals RESET_VALUE with RO bits equal to hw_ro.
REQ-029 Write 'hA5A5A5A5 to register 1 (all RW), read back -> 'hA5A5A5A5; write to BASE_ADDR+40 -> up_wack=1, no state change.
REQ-030 Register 2 bit 0 W1C: pulse hw_set bit 0 -> read 'h1; write 'h1 same cycle as hw_set -> still 'h1; write 'h1 alone -> 'h0.
REQ-031 Register 3 bit 4 W1S: write 'h10 -> reg_pulse bit 4 high exactly one cycle; read -> bit 4 = 0.
REQ-032 Write and read register 1 same cycle (old 'h0, new 'h1234) -> read returns 'h0; next read 'h1234; reset asserted mid-stream -> up_rack dropped.
REQ-033 REGMAP_IRQ_EN: set register 2 W1C bit with mask 0 -> irq=0; write mask 'h4 -> irq=1 next cycle; clear status -> irq=0.
